// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the I2C byte master
package i2c_pkg;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT,
      ACK,
      STOP,
      RESP
   } i2cState_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// rtl/i2c_quarter_timer.sv - quarter-SCL-period down-counter with reload and stretch hold
module i2c_quarter_timer #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic reload,
   input  logic hold,
   output logic tick
);

   localparam logic [15:0] LoadVal = 16'(CLK_DIV - 1);

   logic [15:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (reload || (run && (hold || count == 16'd0))) begin
         count <= LoadVal;
      end else if (run) begin
         count <= count - 16'd1;
      end
   end

   assign tick = run & ~reload & ~hold & (count == 16'd0);

endmodule

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master engine for the PMOD I2C lane
// Optional slave clock stretching: I2C_CLOCK_STRETCH_EN
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_byte,
   input  logic       master_nack,
   output logic       rsp_valid,
   output logic [7:0] rx_byte,
   output logic       ack_n,
   output logic       rsp_err,
   output logic       busy,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_o,
   output logic       sda_o,
   output logic       scl_t,
   output logic       sda_t
);

`ifdef I2C_CLOCK_STRETCH_EN
   localparam bit StretchEn = 1'b1;
`else
   localparam bit StretchEn = 1'b0;
`endif

   i2cState_t  state, stateNext;
   logic [1:0] quarter, quarterNext;
   logic [2:0] bitIdx, bitNext;
   logic [7:0] txReg, rxShift, rxByteReg;
   logic       readReg, nackReg, busyReg, errReg, ackNReg;
   logic       sclT, sdaT, sclNext, sdaNext;
   logic [1:0] sclSyncFf, sdaSyncFf;
   logic       sclSync, sdaSync;
   logic       accept, tick, timerRun, stretchQuarter, stretchHold;
   logic [7:0] txSel;
   logic       readSel, nackSel;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid & cmd_ready;

   // On the accept cycle the command registers are not loaded yet, so look at the inputs.
   assign txSel   = (state == IDLE) ? tx_byte : txReg;
   assign readSel = (state == IDLE) ? (cmd == CMD_READ) : readReg;
   assign nackSel = (state == IDLE) ? master_nack : nackReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclSyncFf <= 2'b11;
         sdaSyncFf <= 2'b11;
      end else begin
         sclSyncFf <= {sclSyncFf[0], scl_i};
         sdaSyncFf <= {sdaSyncFf[0], sda_i};
      end
   end

   assign sclSync = sclSyncFf[1];
   assign sdaSync = sdaSyncFf[1];

   // Quarters that follow an SCL release are where a slave may hold the clock low.
   assign stretchQuarter = ((state == START || state == STOP) && quarter == Q1) ||
                           ((state == BIT || state == ACK) && quarter == Q2);
   assign stretchHold    = StretchEn & stretchQuarter & ~sclSync;
   assign timerRun       = (state == START) || (state == BIT) ||
                           (state == ACK) || (state == STOP);

   i2c_quarter_timer #(
      .CLK_DIV (CLK_DIV)
   ) uQuarterTimer (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (timerRun),
      .reload (accept),
      .hold   (stretchHold),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         quarter <= Q0;
         bitIdx  <= 3'd7;
      end else begin
         state   <= stateNext;
         quarter <= quarterNext;
         bitIdx  <= bitNext;
      end
   end

   always_comb begin
      stateNext   = state;
      quarterNext = quarter;
      bitNext     = bitIdx;
      sclNext     = sclT;
      sdaNext     = sdaT;

      case (state)
         IDLE: begin
            if (accept) begin
               quarterNext = Q0;
               bitNext     = 3'd7;
               if (cmd == CMD_START)     stateNext = START;
               else if (!busyReg)        stateNext = RESP;
               else if (cmd == CMD_STOP) stateNext = STOP;
               else                      stateNext = BIT;
            end
         end
         START, STOP, ACK: begin
            if (tick) begin
               quarterNext = quarter + 2'd1;
               if (quarter == Q3) stateNext = RESP;
            end
         end
         BIT: begin
            if (tick) begin
               quarterNext = quarter + 2'd1;
               if (quarter == Q3) begin
                  if (bitIdx == 3'd0) stateNext = ACK;
                  else                bitNext   = bitIdx - 3'd1;
               end
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      // Line levels are set on entry to each quarter and held for its duration.
      case (stateNext)
         START: begin
            case (quarterNext)
               Q0:      sdaNext = 1'b1;
               Q1:      begin sclNext = 1'b1; sdaNext = 1'b1; end
               Q2:      begin sclNext = 1'b1; sdaNext = 1'b0; end
               default: begin sclNext = 1'b0; sdaNext = 1'b0; end
            endcase
         end
         BIT: begin
            sclNext = quarterNext[1];
            sdaNext = readSel ? 1'b1 : txSel[bitNext];
         end
         ACK: begin
            sclNext = quarterNext[1];
            sdaNext = readSel ? nackSel : 1'b1;
         end
         STOP: begin
            case (quarterNext)
               Q0:      begin sclNext = 1'b0; sdaNext = 1'b0; end
               Q1:      begin sclNext = 1'b1; sdaNext = 1'b0; end
               default: begin sclNext = 1'b1; sdaNext = 1'b1; end
            endcase
         end
         RESP: begin
            if (state == ACK) sclNext = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclT      <= 1'b1;
         sdaT      <= 1'b1;
         txReg     <= '0;
         rxShift   <= '0;
         rxByteReg <= '0;
         readReg   <= 1'b0;
         nackReg   <= 1'b0;
         busyReg   <= 1'b0;
         errReg    <= 1'b0;
         ackNReg   <= 1'b0;
      end else begin
         sclT <= sclNext;
         sdaT <= sdaNext;
         if (accept) begin
            txReg   <= tx_byte;
            readReg <= (cmd == CMD_READ);
            nackReg <= master_nack;
            errReg  <= (cmd != CMD_START) && !busyReg;
         end
         if (tick) begin
            if (state == BIT && quarter == Q2) rxShift <= {rxShift[6:0], sdaSync};
            if (state == ACK && quarter == Q2) begin
               ackNReg   <= sdaSync;
               rxByteReg <= rxShift;
            end
            if (state == START && quarter == Q3) busyReg <= 1'b1;
            if (state == STOP && quarter == Q3)  busyReg <= 1'b0;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign rx_byte   = rxByteReg;
   assign ack_n     = ackNReg;
   assign rsp_err   = errReg;
   assign busy      = busyReg;
   assign scl_o     = 1'b0;
   assign sda_o     = 1'b0;
   assign scl_t     = sclT;
   assign sda_t     = sdaT;

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed self-checking bench for i2c_byte_master
module tb_i2c_byte_master;
   import i2c_pkg::*;

   localparam int Div = 4;
`ifdef I2C_CLOCK_STRETCH_EN
   localparam int SyncExtra    = 2;
   localparam int StretchDelay = 40;
`else
   localparam int SyncExtra    = 0;
   localparam int StretchDelay = 0;
`endif
   localparam int LatStart = 4 * Div + 1;
   localparam int LatStop  = 4 * Div + 1 + SyncExtra;
   localparam int LatByte  = 36 * Div + 1 + 9 * SyncExtra;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] tx_byte = 8'h00;
   logic       master_nack = 1'b0;
   logic       cmd_ready, rsp_valid, ack_n, rsp_err, busy;
   logic [7:0] rx_byte;
   logic       scl_o, sda_o, scl_t, sda_t;
   logic       slaveScl = 1'b1;
   logic       slaveSda = 1'b1;
   wire        sclBus = (scl_t ? 1'b1 : scl_o) & slaveScl;
   wire        sdaBus = (sda_t ? 1'b1 : sda_o) & slaveSda;

   int checkCnt = 0;
   int failCnt = 0;
   int lat, base, startBefore, stopBefore, edgeBefore;
   int edgeCnt = 0;
   int startCnt = 0;
   int stopCnt = 0;
   logic [8:0] monShift = '0;
   logic prevScl = 1'b1;
   logic prevSda = 1'b1;

   i2c_byte_master #(.CLK_DIV(Div)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .tx_byte(tx_byte), .master_nack(master_nack), .rsp_valid(rsp_valid),
      .rx_byte(rx_byte), .ack_n(ack_n), .rsp_err(rsp_err), .busy(busy),
      .scl_i(sclBus), .sda_i(sdaBus), .scl_o(scl_o), .sda_o(sda_o),
      .scl_t(scl_t), .sda_t(sda_t)
   );

   always #5 clk = ~clk;

   // Bus monitor: START/STOP conditions, any line change, SDA at each SCL rise.
   always @(negedge clk) begin
      if (sclBus !== prevScl || sdaBus !== prevSda) edgeCnt <= edgeCnt + 1;
      if (prevScl && sclBus && prevSda && !sdaBus) startCnt <= startCnt + 1;
      if (prevScl && sclBus && !prevSda && sdaBus) stopCnt <= stopCnt + 1;
      if (!prevScl && sclBus) monShift <= {monShift[7:0], sdaBus};
      prevScl <= sclBus;
      prevSda <= sdaBus;
   end

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic doCmd(input logic [1:0] c, input logic [7:0] d, input logic n,
                        output int latency);
      @(negedge clk);
      cmd = c; tx_byte = d; master_nack = n; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      latency = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            latency = i;
            break;
         end
      end
      checkEq("rsp_seen", (latency != 0), 1);
   endtask

   task automatic slaveAck();
      repeat (8) @(negedge sclBus);
      slaveSda = 1'b0;
      @(negedge sclBus);
      slaveSda = 1'b1;
   endtask

   task automatic slaveSend(input logic [7:0] d);
      slaveSda = d[7];
      for (int i = 6; i >= 0; i--) begin
         @(negedge sclBus);
         slaveSda = d[i];
      end
      @(negedge sclBus);
      slaveSda = 1'b1;
   endtask

   task automatic slaveStretch();
      repeat (2) @(negedge sclBus);
      slaveScl = 1'b0;
      for (int i = 0; i < 200 && !scl_t; i++) @(negedge clk);
      repeat (40) @(negedge clk);
      slaveScl = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkEq("rst_scl_t", scl_t, 1);
      checkEq("rst_sda_t", sda_t, 1);
      checkEq("rst_scl_o", scl_o, 0);
      checkEq("rst_sda_o", sda_o, 0);
      checkEq("rst_cmd_ready", cmd_ready, 1);
      checkEq("rst_rsp_valid", rsp_valid, 0);
      checkEq("rst_rx_byte", rx_byte, 0);
      checkEq("rst_ack_n", ack_n, 0);
      checkEq("rst_rsp_err", rsp_err, 0);
      checkEq("rst_busy", busy, 0);
      rst_n = 1'b1;

      // Reset in the middle of WRITE bit 3.
      doCmd(CMD_START, 8'h00, 1'b0, lat);
      @(negedge clk);
      cmd = CMD_WRITE; tx_byte = 8'h00; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (50 + 3 * SyncExtra) @(negedge clk);
      checkEq("midwrite_lines_low", {scl_t, sda_t}, 2'b00);
      #2 rst_n = 1'b0;
      #1 checkEq("async_rst_lines", {scl_t, sda_t}, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkEq("post_rst_ready", cmd_ready, 1);
      checkEq("post_rst_busy", busy, 0);
      checkEq("post_rst_rsp_valid", rsp_valid, 0);

      // START then WRITE 0xB0 acknowledged by the slave.
      startBefore = startCnt;
      doCmd(CMD_START, 8'h00, 1'b0, lat);
      checkEq("start_latency", lat, LatStart);
      checkEq("start_busy", busy, 1);
      checkEq("start_err", rsp_err, 0);
      checkEq("start_condition", startCnt, startBefore + 1);
      startBefore = startCnt;
      stopBefore = stopCnt;
      fork
         doCmd(CMD_WRITE, 8'hB0, 1'b0, lat);
         slaveAck();
      join
      checkEq("wr_b0_latency", lat, LatByte);
      checkEq("wr_b0_rx", rx_byte, 8'hB0);
      checkEq("wr_b0_ack_n", ack_n, 0);
      checkEq("wr_b0_err", rsp_err, 0);
      checkEq("wr_b0_busy", busy, 1);
      checkEq("wr_b0_bus_bits", monShift, {8'hB0, 1'b0});
      checkEq("wr_b0_sda_stable", {startCnt, stopCnt}, {startBefore, stopBefore});

      // WRITE 0x55 with nobody answering.
      doCmd(CMD_WRITE, 8'h55, 1'b0, lat);
      checkEq("wr_55_ack_n", ack_n, 1);
      checkEq("wr_55_rx", rx_byte, 8'h55);
      checkEq("wr_55_err", rsp_err, 0);

      // READ 0x5A with master NACK, then STOP.
      fork
         doCmd(CMD_READ, 8'h00, 1'b1, lat);
         slaveSend(8'h5A);
      join
      checkEq("rd_latency", lat, LatByte);
      checkEq("rd_rx", rx_byte, 8'h5A);
      checkEq("rd_ack_n", ack_n, 1);
      checkEq("rd_bus_bits", monShift, {8'h5A, 1'b1});
      stopBefore = stopCnt;
      doCmd(CMD_STOP, 8'h00, 1'b0, lat);
      checkEq("stop_latency", lat, LatStop);
      checkEq("stop_busy", busy, 0);
      checkEq("stop_condition", stopCnt, stopBefore + 1);

      // Commands that need an open transaction are rejected while idle.
      edgeBefore = edgeCnt;
      doCmd(CMD_WRITE, 8'hFF, 1'b0, lat);
      checkEq("err_wr_latency", lat, 1);
      checkEq("err_wr_flag", rsp_err, 1);
      checkEq("err_wr_rx_kept", rx_byte, 8'h5A);
      checkEq("err_wr_ack_kept", ack_n, 1);
      doCmd(CMD_READ, 8'h00, 1'b0, lat);
      checkEq("err_rd_flag", rsp_err, 1);
      doCmd(CMD_STOP, 8'h00, 1'b0, lat);
      checkEq("err_stop_flag", rsp_err, 1);
      repeat (4) @(negedge clk);
      checkEq("err_no_line_activity", edgeCnt, edgeBefore);

      // Slave clock stretch of 40 clocks at bit 2 Q2.
      doCmd(CMD_START, 8'h00, 1'b0, lat);
      checkEq("start2_err", rsp_err, 0);
      doCmd(CMD_WRITE, 8'hC3, 1'b0, base);
      checkEq("wr_c3_latency", base, LatByte);
      fork
         doCmd(CMD_WRITE, 8'h3C, 1'b0, lat);
         slaveStretch();
      join
      checkEq("stretch_rx", rx_byte, 8'h3C);
      checkEq("stretch_delay_in_range",
              ((lat - base) >= StretchDelay - 2) && ((lat - base) <= StretchDelay + 2), 1);
      doCmd(CMD_STOP, 8'h00, 1'b0, lat);
      checkEq("stop2_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
      $finish;
   end

endmodule
